// File: rtl/button_event_gen_pkg.sv
// Shared types and constant helpers for the button event generator.
// Contains the FSM state encoding and the counter-width functions.
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam int PRESS_CNT_W = 8;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_gen_if.sv
// Button level in, event pulses and status out.
// The master side is the event generator; the slave side is the consumer.
interface button_event_gen_if;

  logic                                        btn_in;
  logic                                        press_pulse;
  logic                                        release_pulse;
  logic                                        long_pulse;
  logic                                        repeat_pulse;
  logic                                        held;
  logic [button_event_gen_pkg::PRESS_CNT_W-1:0] press_count;

  modport master (
    input  btn_in,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output held,
    output press_count
  );

  modport slave (
    output btn_in,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held,
    input  press_count
  );

endinterface

// File: rtl/button_event_gen_ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_FREQ/1000-1 and flags the terminal count.
// A synchronous clear restarts the millisecond phase.
module ms_tick_gen
  import button_event_gen_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV  = CLK_FREQ / 1000;
  localparam int PS_W = clog2(DIV);
  localparam logic [PS_W-1:0] TC = PS_W'(DIV - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + PS_W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long/repeat pulses.
// Synchronizer, event FSM, millisecond counter and press counter.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic               clk,
  input  logic               rst_a_n,
  button_event_gen_if.master bus
);

  localparam int MS_W = clog2(max3(LONG_PRESS_MS, REPEAT_MS, 2));
  localparam logic [MS_W-1:0] LONG_TC = MS_W'(LONG_PRESS_MS - 1);
  localparam logic [MS_W-1:0] REP_TC  = MS_W'((REPEAT_MS == 0) ? 0 : REPEAT_MS - 1);
  localparam bit              REP_EN  = (REPEAT_MS != 0);

  logic                   sync1_q, btn_s_q;
  state_t                 state_q, state_d;
  logic [MS_W-1:0]        ms_cnt_q, ms_cnt_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q;
  logic                   press_q, release_q, long_q, repeat_q, held_q;
  logic                   press_d, release_d, long_d, repeat_d;
  logic                   tick;
  logic                   trans;

  ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk     (clk),
    .rst_a_n (rst_a_n),
    .clr_i   (trans),
    .tick_o  (tick)
  );

  // Release takes priority over a coincident long/repeat terminal tick.
  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!btn_s_q) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (tick) begin
          if (ms_cnt_q == LONG_TC) begin
            long_d  = 1'b1;
            state_d = LONG;
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end
      LONG: begin
        if (!btn_s_q) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (REP_EN && tick) begin
          if (ms_cnt_q == REP_TC) begin
            repeat_d = 1'b1;
            ms_cnt_d = '0;
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    trans = (state_d != state_q);
    if (trans) ms_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync1_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      state_q     <= IDLE;
      ms_cnt_q    <= '0;
      press_cnt_q <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      sync1_q     <= bus.btn_in;
      btn_s_q     <= sync1_q;
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      press_cnt_q <= press_cnt_q + PRESS_CNT_W'(press_d);
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      held_q      <= (state_d != IDLE);
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.held          = held_q;
  assign bus.press_count   = press_cnt_q;

endmodule
